// File: rtl/mon_data_fifo.sv
// mon_data_fifo: per-lane monitoring-data FIFO with registered pop output,
// default-word presentation when empty, and sticky overflow/underflow flags.
module mon_data_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 26
) (
  input  logic                       clk,
  input  logic                       Reset,
  input  logic                       LoadData,
  input  logic                       LoadDefaultData,
  input  logic                       RdFifo,
  input  logic [DATA_W-1:0]          RegData,
  input  logic [DATA_W-1:0]          DefaultData,
  input  logic                       ClearErrors,
  output logic [DATA_W-1:0]          DataOut,
  output logic                       DataIsDefault,
  output logic                       FifoEmpty,
  output logic                       FifoFull,
  output logic [$clog2(DEPTH+1)-1:0] Level,
  output logic                       OverflowError,
  output logic                       UnderflowError
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic              r_empty;
  logic              r_full;
  logic [DATA_W-1:0] r_data_out;
  logic              r_is_default;
  logic              r_ovf;
  logic              r_udf;

  logic              w_rd_ok;
  logic              w_wr_ok;
  logic              w_default;
  logic              w_ovf_evt;
  logic              w_udf_evt;
  logic [LW-1:0]     w_level_nxt;

  // A pop needs stored data; a write is accepted when there is room or the
  // same-cycle pop frees the head slot. An empty FIFO never falls through.
  assign w_rd_ok   = RdFifo & ~r_empty;
  assign w_wr_ok   = LoadData & (~r_full | w_rd_ok);
  assign w_default = ~w_rd_ok & LoadDefaultData & r_empty;
  assign w_ovf_evt = LoadData & ~w_wr_ok;
  assign w_udf_evt = RdFifo & r_empty;

  // Next occupancy: +1 on write only, -1 on pop only, unchanged otherwise.
  always_comb begin
    w_level_nxt = r_level;
    if (w_wr_ok && !w_rd_ok)
      w_level_nxt = r_level + LW'(1);
    else if (!w_wr_ok && w_rd_ok)
      w_level_nxt = r_level - LW'(1);
  end

  // Storage array; contents are don't-care after reset, so it has no reset.
  always_ff @(posedge clk) begin
    if (w_wr_ok)
      r_mem[r_wr_ptr] <= RegData;
  end

  // Pointers, occupancy and registered empty/full status.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
    end else begin
      if (w_wr_ok)
        r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_ok)
        r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= w_level_nxt;
      r_empty <= (w_level_nxt == '0);
      r_full  <= (w_level_nxt == LW'(DEPTH));
    end
  end

  // Output word: pop has priority over default presentation, else hold.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_data_out   <= '0;
      r_is_default <= 1'b0;
    end else if (w_rd_ok) begin
      r_data_out   <= r_mem[r_rd_ptr];
      r_is_default <= 1'b0;
    end else if (w_default) begin
      r_data_out   <= DefaultData;
      r_is_default <= 1'b1;
    end
  end

  // Sticky error flags; a new error in the clearing cycle wins over the clear.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (w_ovf_evt)
        r_ovf <= 1'b1;
      else if (ClearErrors)
        r_ovf <= 1'b0;
      if (w_udf_evt)
        r_udf <= 1'b1;
      else if (ClearErrors)
        r_udf <= 1'b0;
    end
  end

  assign DataOut        = r_data_out;
  assign DataIsDefault  = r_is_default;
  assign FifoEmpty      = r_empty;
  assign FifoFull       = r_full;
  assign Level          = r_level;
  assign OverflowError  = r_ovf;
  assign UnderflowError = r_udf;

endmodule

// File: tb/tb_mon_data_fifo.sv
// tb_mon_data_fifo: directed vectors with hand-computed expectations.
module tb_mon_data_fifo;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 26;

  logic              clk;
  logic              Reset;
  logic              LoadData;
  logic              LoadDefaultData;
  logic              RdFifo;
  logic [DATA_W-1:0] RegData;
  logic [DATA_W-1:0] DefaultData;
  logic              ClearErrors;
  logic [DATA_W-1:0] DataOut;
  logic              DataIsDefault;
  logic              FifoEmpty;
  logic              FifoFull;
  logic [2:0]        Level;
  logic              OverflowError;
  logic              UnderflowError;

  int n_checks = 0;
  int n_errors = 0;

  mon_data_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk            (clk),
    .Reset          (Reset),
    .LoadData       (LoadData),
    .LoadDefaultData(LoadDefaultData),
    .RdFifo         (RdFifo),
    .RegData        (RegData),
    .DefaultData    (DefaultData),
    .ClearErrors    (ClearErrors),
    .DataOut        (DataOut),
    .DataIsDefault  (DataIsDefault),
    .FifoEmpty      (FifoEmpty),
    .FifoFull       (FifoFull),
    .Level          (Level),
    .OverflowError  (OverflowError),
    .UnderflowError (UnderflowError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    LoadData        = 1'b0;
    RdFifo          = 1'b0;
    ClearErrors     = 1'b0;
  endtask

  task automatic push(input logic [DATA_W-1:0] d);
    LoadData = 1'b1;
    RegData  = d;
    tick();
    LoadData = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [DATA_W-1:0] exp);
    RdFifo = 1'b1;
    tick();
    RdFifo = 1'b0;
    check(tag, 32'(DataOut), 32'(exp));
    check({tag, "_isdef"}, 32'(DataIsDefault), 32'd0);
  endtask

  initial begin
    Reset           = 1'b1;
    LoadData        = 1'b0;
    LoadDefaultData = 1'b0;
    RdFifo          = 1'b0;
    RegData         = '0;
    DefaultData     = '0;
    ClearErrors     = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_empty", 32'(FifoEmpty), 32'd1);
    check("rst_full",  32'(FifoFull),  32'd0);
    check("rst_level", 32'(Level),     32'd0);
    check("rst_dout",  32'(DataOut),   32'd0);
    check("rst_isdef", 32'(DataIsDefault), 32'd0);
    check("rst_ovf",   32'(OverflowError),  32'd0);
    check("rst_udf",   32'(UnderflowError), 32'd0);
    Reset = 1'b0;
    tick();

    // Two writes then two pops, order and latency
    push(26'h0A51234);
    push(26'h0B00001);
    check("t1_level2", 32'(Level), 32'd2);
    check("t1_empty0", 32'(FifoEmpty), 32'd0);
    pop_check("t1_pop0", 26'h0A51234);
    pop_check("t1_pop1", 26'h0B00001);
    check("t1_empty", 32'(FifoEmpty), 32'd1);
    check("t1_level0", 32'(Level), 32'd0);

    // Fill, then overflow
    push(26'h0000001);
    push(26'h0000002);
    push(26'h0000003);
    push(26'h0000004);
    check("t2_full",  32'(FifoFull), 32'd1);
    check("t2_level", 32'(Level),    32'd4);
    push(26'h0000005);
    check("t2_ovf",   32'(OverflowError), 32'd1);
    check("t2_level_drop", 32'(Level), 32'd4);
    ClearErrors = 1'b1;
    tick();
    ClearErrors = 1'b0;
    check("t2_ovf_clr", 32'(OverflowError), 32'd0);

    // Write + pop at full, then drain across the pointer wrap
    LoadData = 1'b1;
    RdFifo   = 1'b1;
    RegData  = 26'h0000006;
    tick();
    idle();
    check("t3_wr_rd_dout", 32'(DataOut), 32'h1);
    check("t3_level", 32'(Level), 32'd4);
    check("t3_full",  32'(FifoFull), 32'd1);
    check("t3_ovf",   32'(OverflowError), 32'd0);
    pop_check("t3_pop2", 26'h0000002);
    pop_check("t3_pop3", 26'h0000003);
    pop_check("t3_pop4", 26'h0000004);
    pop_check("t3_pop6", 26'h0000006);
    check("t3_empty", 32'(FifoEmpty), 32'd1);

    // Default presentation held for 10 cycles
    DefaultData     = 26'h3FFFFFF;
    LoadDefaultData = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("t4_dout_def", 32'(DataOut), 32'h3FFFFFF);
    check("t4_isdef",    32'(DataIsDefault), 32'd1);
    check("t4_level0",   32'(Level), 32'd0);
    check("t4_empty",    32'(FifoEmpty), 32'd1);
    push(26'h0010002);
    check("t4_hold_wr",  32'(DataOut), 32'h3FFFFFF);
    check("t4_level1",   32'(Level), 32'd1);
    tick();
    check("t4_hold_idle", 32'(DataOut), 32'h3FFFFFF);
    check("t4_isdef_hold", 32'(DataIsDefault), 32'd1);
    pop_check("t4_pop", 26'h0010002);
    LoadDefaultData = 1'b0;

    // Underflow
    RdFifo = 1'b1;
    tick();
    RdFifo = 1'b0;
    check("t5_udf",  32'(UnderflowError), 32'd1);
    check("t5_dout", 32'(DataOut), 32'h0010002);
    ClearErrors = 1'b1;
    tick();
    ClearErrors = 1'b0;
    check("t5_udf_clr", 32'(UnderflowError), 32'd0);
    LoadData = 1'b1;
    RdFifo   = 1'b1;
    RegData  = 26'h0000007;
    tick();
    idle();
    check("t5_wr_rd_level", 32'(Level), 32'd1);
    check("t5_wr_rd_udf",   32'(UnderflowError), 32'd1);
    check("t5_no_fallthru", 32'(DataOut), 32'h0010002);
    pop_check("t5_pop7", 26'h0000007);

    // Async reset mid-burst with Level=3
    push(26'h0000011);
    push(26'h0000012);
    push(26'h0000013);
    check("t6_level3", 32'(Level), 32'd3);
    LoadData = 1'b1;
    RegData  = 26'h0000014;
    #2;
    Reset = 1'b1;
    #1;
    check("t6_ar_level", 32'(Level), 32'd0);
    check("t6_ar_empty", 32'(FifoEmpty), 32'd1);
    check("t6_ar_dout",  32'(DataOut), 32'd0);
    check("t6_ar_udf",   32'(UnderflowError), 32'd0);
    LoadData = 1'b0;
    tick();
    Reset = 1'b0;
    tick();
    push(26'h0000021);
    push(26'h0000022);
    check("t6_level2", 32'(Level), 32'd2);
    pop_check("t6_pop21", 26'h0000021);
    pop_check("t6_pop22", 26'h0000022);
    check("t6_empty", 32'(FifoEmpty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mon_data_fifo.md
Name: mon_data_fifo

Overview:
- Per-lane monitoring-data FIFO; 8 instances sit directly downstream of the monitoring-frame FSM, one per Aurora lane slot.
- Stores register-readback words on that FSM's per-lane load strobe and returns FifoEmpty/FifoFull status to it.
- On a read strobe, pops the head word into a registered output. When the FIFO is empty in a send-frame cycle, it presents a default word instead.
- The Aurora frame builder samples DataOut two cycles after SendFrame.

Parameters:
- DEPTH, 4, number of stored words; power of two, at least 2.
- DATA_W, 26, word width (10-bit address + 16-bit value).

Ports:
- clk  in  1  160 MHz clock
- Reset  in  1  asynchronous, active-high reset
- LoadData  in  1  write RegData into FIFO this cycle
- LoadDefaultData  in  1  level; lane has no data, present DefaultData
- RdFifo  in  1  pop head word into DataOut this cycle
- RegData  in  DATA_W  register-readback word
- DefaultData  in  DATA_W  auto/default word for this lane
- ClearErrors  in  1  synchronous pulse, clears sticky error flags
- DataOut  out  DATA_W  registered output word
- DataIsDefault  out  1  DataOut holds DefaultData, not FIFO data
- FifoEmpty  out  1  level == 0
- FifoFull  out  1  level == DEPTH
- Level  out  $clog2(DEPTH+1)  current occupancy
- OverflowError  out  1  sticky; write dropped while full
- UnderflowError  out  1  sticky; read requested while empty

Behaviour:
- Reset (async assert, sync release) forces:
  - pointers and Level = 0, FifoEmpty=1, FifoFull=0
  - DataOut=0, DataIsDefault=0
  - OverflowError=0, UnderflowError=0
  - memory contents don't-care
- Reset asserted mid-operation discards all stored words immediately; no partial pop completes.
- Storage: DEPTH x DATA_W array, write and read pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH. Level is tracked by a separate counter.
- FifoEmpty, FifoFull and Level are registered state; they reflect the occupancy after the last edge, with no combinational path from the inputs.
- Write accepted = LoadData & (~FifoFull | rd_ok), where rd_ok = RdFifo & ~FifoEmpty:
  - mem[wr_ptr] <= RegData, wr_ptr+1
- Write while full without rd_ok: word dropped, pointers unchanged, OverflowError <= 1.
- Pop when rd_ok:
  - DataOut <= mem[rd_ptr], DataIsDefault <= 0, rd_ptr+1
  - latency: DataOut valid the cycle after RdFifo
- RdFifo while empty: no pop, UnderflowError <= 1. DataOut follows the default rule below if applicable; otherwise it holds.
- Default presentation when ~rd_ok & LoadDefaultData & FifoEmpty: DataOut <= DefaultData, DataIsDefault <= 1. No storage is written, so a LoadDefaultData held high for many cycles never fills the FIFO.
- Neither rd_ok nor the default condition: DataOut and DataIsDefault hold.
- Simultaneous write + pop: both take effect; Level unchanged; legal at full (the pop frees the slot) and at any level above 0.
- Write while empty + RdFifo same cycle: write accepted, pop not performed (no fall-through), UnderflowError set.
- Level update: +1 on write only, -1 on pop only, unchanged on both or neither.
- ClearErrors clears both sticky flags. If a new error event occurs in the same cycle, the set wins.
- Priority at DataOut: pop > default > hold.

Test Plan:
- Reset, DEPTH=4 -> FifoEmpty=1, Level=0, DataOut=0, errors 0. Write 0x0A5_1234 and 0x0B0_0001 on consecutive cycles, then RdFifo two cycles -> DataOut=0x0A5_1234 then 0x0B0_0001 (each 1 cycle after RdFifo), DataIsDefault=0, FifoEmpty=1 at end.
- Fill 4 words -> FifoFull=1, Level=4. 5th LoadData alone -> dropped, OverflowError=1, Level=4. ClearErrors -> OverflowError=0.
- At full, LoadData+RdFifo same cycle -> head popped, new word stored, Level stays 4. Then 4 pops over pointer wrap -> original order preserved.
- Empty FIFO, LoadDefaultData=1 held 10 cycles with DefaultData=0x3FF_FFFF -> DataOut=0x3FF_FFFF, DataIsDefault=1, Level stays 0. Then write 0x001_0002 -> DataOut holds the default until RdFifo; after the pop, DataOut=0x001_0002, DataIsDefault=0.
- RdFifo while empty -> UnderflowError=1, DataOut unchanged. Empty FIFO with LoadData+RdFifo same cycle -> Level=1, UnderflowError=1.
- Reset asserted asynchronously mid-burst with Level=3 -> all outputs at reset values before the next clk edge. Release -> normal writes resume at slot 0.
